// File: rtl/spi_target_sbus.sv
// SPI target with sbus register access: captures the master's bit stream into an RX image
// and returns a bus-preloaded TX image on SDO. All SPI pins are oversampled on BUS_CLK.
module spi_target_sbus #(
   parameter int unsigned          ABUSWIDTH = 16,
   parameter logic [ABUSWIDTH-1:0] BASEADDR  = '0,
   parameter logic [ABUSWIDTH-1:0] HIGHADDR  = '0,
   parameter int unsigned          MEM_BYTES = 2
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   input  logic                 SCLK,
   input  logic                 SDI,
   input  logic                 SEN,
   input  logic                 SLD,
   output logic                 SDO
);

   localparam int unsigned          W       = MEM_BYTES * 8;
   localparam logic [ABUSWIDTH-1:0] SPAN    = HIGHADDR - BASEADDR;
   localparam logic [7:0]           VERSION = 8'd1;

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LD} state_t;

   state_t         state_q, state_d;
   logic [2:0]     sclk_sync_q, sdi_sync_q, sen_sync_q, sld_sync_q;
   logic [W-1:0]   sr_q, sr_d;
   logic [15:0]    cnt_q, cnt_d, bitcnt_q, bitcnt_d;
   logic           done_q, done_d, ovf_q, ovf_d, sdo_q, sdo_d, arm_q, arm_d;
   logic [1:0]     settle_q, settle_d;
   logic [7:0]     rdata_q, rdata_d, rd_mux;
   logic [7:0]     tx_mem_q [MEM_BYTES];
   logic [7:0]     tx_mem_d [MEM_BYTES];
   logic [7:0]     rx_mem_q [MEM_BYTES];
   logic [7:0]     rx_mem_d [MEM_BYTES];
   logic [ABUSWIDTH-1:0] off;
   logic           in_range, rd_en, wr_en, soft_rst, busy;
   logic           sclk_rise, sclk_fall, sen_rise, sen_fall, sld_rise;

   // Sync stages: [0] first FF, [1] second FF, [2] previous value for edge detection
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   // arm_q blocks a SEN that was already high across a reset from looking like a new frame
   assign sen_rise  = sen_sync_q[1] & ~sen_sync_q[2] & arm_q;
   assign sen_fall  = ~sen_sync_q[1] & sen_sync_q[2];
   assign sld_rise  = sld_sync_q[1] & ~sld_sync_q[2];

   assign off      = BUS_ADD - BASEADDR;
   assign in_range = (off <= SPAN);
   assign rd_en    = BUS_RD & in_range;
   assign wr_en    = BUS_WR & in_range;
   assign soft_rst = wr_en & (off == ABUSWIDTH'(0));

   assign BUS_DATA_OUT = rdata_q;
   assign SDO          = sdo_q;

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         sdi_sync_q  <= '0;
         sen_sync_q  <= '0;
         sld_sync_q  <= '0;
         sr_q        <= '0;
         cnt_q       <= '0;
         bitcnt_q    <= '0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         sdo_q       <= 1'b0;
         arm_q       <= 1'b0;
         settle_q    <= '0;
         rdata_q     <= '0;
         tx_mem_q    <= '{default: '0};
         rx_mem_q    <= '{default: '0};
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
         sdi_sync_q  <= {sdi_sync_q[1:0], SDI};
         sen_sync_q  <= {sen_sync_q[1:0], SEN};
         sld_sync_q  <= {sld_sync_q[1:0], SLD};
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         bitcnt_q    <= bitcnt_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         sdo_q       <= sdo_d;
         arm_q       <= arm_d;
         settle_q    <= settle_d;
         rdata_q     <= rdata_d;
         tx_mem_q    <= tx_mem_d;
         rx_mem_q    <= rx_mem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (soft_rst) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (sen_rise) state_d = SHIFT;
            SHIFT:   if (sen_fall) state_d = WAIT_LD;
            WAIT_LD: if (sld_rise) state_d = IDLE;
                     else if (sen_rise) state_d = SHIFT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == SHIFT);
   end

   always_comb begin
      rd_mux = '0;
      if (off == ABUSWIDTH'(0)) rd_mux = VERSION;
      if (off == ABUSWIDTH'(1)) rd_mux = {5'b0, ovf_q, busy, done_q};
      if (off == ABUSWIDTH'(2)) rd_mux = bitcnt_q[7:0];
      if (off == ABUSWIDTH'(3)) rd_mux = bitcnt_q[15:8];
      for (int unsigned i = 0; i < MEM_BYTES; i++) begin
         if (off == ABUSWIDTH'(16 + i))             rd_mux = tx_mem_q[i];
         if (off == ABUSWIDTH'(16 + MEM_BYTES + i)) rd_mux = rx_mem_q[i];
      end
   end

   always_comb begin
      tx_mem_d = tx_mem_q;
      rx_mem_d = rx_mem_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      sdo_d    = sdo_q;
      arm_d    = arm_q;
      settle_d = settle_q;
      rdata_d  = rdata_q;

      if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
      if ((settle_q == 2'd3) && !sen_sync_q[1]) arm_d = 1'b1;
      if (rd_en) rdata_d = rd_mux;

      // Bus clears come first so a same-cycle flag set below takes priority
      if (wr_en) begin
         for (int unsigned i = 0; i < MEM_BYTES; i++)
            if (off == ABUSWIDTH'(16 + i)) tx_mem_d[i] = BUS_DATA_IN;
         if (off == ABUSWIDTH'(1)) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
         end
      end

      if (soft_rst) begin
         sr_d     = '0;
         cnt_d    = '0;
         bitcnt_d = '0;
         done_d   = 1'b0;
         ovf_d    = 1'b0;
         sdo_d    = 1'b0;
         arm_d    = 1'b0;
      end else begin
         if ((state_q == IDLE && sen_rise) || (state_q == WAIT_LD && !sld_rise && sen_rise)) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++)
               sr_d[W-1-8*i -: 8] = tx_mem_q[i];
            cnt_d = '0;
            sdo_d = tx_mem_q[0][7];
         end
         if (state_q == SHIFT) begin
            if (sen_fall) begin
               bitcnt_d = cnt_q;
               sdo_d    = 1'b0;
            end else begin
               if (sclk_rise) begin
                  sr_d = {sr_q[W-2:0], sdi_sync_q[1]};
                  if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                  if (cnt_q >= 16'(W)) ovf_d = 1'b1;
               end
               if (sclk_fall) sdo_d = sr_q[W-1];
            end
         end
         if (state_q == WAIT_LD && sld_rise) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++)
               rx_mem_d[i] = sr_q[W-1-8*i -: 8];
            done_d = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_target_sbus.sv
// Directed bench for spi_target_sbus: frames, status flags, overflow, short frames,
// same-cycle collisions, reset mid-frame and a fast-SCLK random sweep.
module tb_spi_target_sbus;

   localparam logic [15:0] BASE = 16'h1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] add = '0;
   logic [7:0]  din = '0;
   logic [7:0]  dout;
   logic        rd = 1'b0, wr = 1'b0;
   logic        sclk = 1'b0, sdi = 1'b0, sen = 1'b0, sld = 1'b0;
   logic        sdo;

   int total = 0;
   int bad   = 0;

   spi_target_sbus #(
      .ABUSWIDTH(16),
      .BASEADDR (16'h1000),
      .HIGHADDR (16'h10FF),
      .MEM_BYTES(2)
   ) dut (
      .BUS_CLK     (clk),
      .BUS_RST     (rst),
      .BUS_ADD     (add),
      .BUS_DATA_IN (din),
      .BUS_DATA_OUT(dout),
      .BUS_RD      (rd),
      .BUS_WR      (wr),
      .SCLK        (sclk),
      .SDI         (sdi),
      .SEN         (sen),
      .SLD         (sld),
      .SDO         (sdo)
   );

   always #5 clk = ~clk;

   // All tasks start and end on a negedge of clk
   task automatic bus_write(input logic [15:0] offs, input logic [7:0] d);
      add = BASE + offs; din = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] offs, output logic [7:0] d);
      add = BASE + offs; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = dout;
   endtask

   task automatic sen_on();
      sen = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic sen_off();
      sen = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic sld_pulse();
      sld = 1'b1;
      repeat (2) @(negedge clk);
      sld = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] data, input int nbits, input int half,
                            output logic [31:0] sdo_bits);
      sdo_bits = '0;
      for (int i = nbits - 1; i >= 0; i--) begin
         sdi = data[i];
         repeat (half) @(negedge clk);
         sdo_bits = {sdo_bits[30:0], sdo};
         sclk = 1'b1;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (half) @(negedge clk);
   endtask

   task automatic full_frame(input logic [31:0] data, input int nbits, input int half,
                             output logic [31:0] sdo_bits);
      sen_on();
      send_bits(data, nbits, half, sdo_bits);
      sen_off();
      sld_pulse();
   endtask

   task automatic test_reset();
      logic [7:0] r;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      total++; if (sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
      repeat (4) @(negedge clk);
      bus_read(16'd1, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", r); end
      bus_read(16'd0, r);
      total++; if (r !== 8'h01) begin bad++; $display("FAIL version got=%h exp=01", r); end
      bus_read(16'd16, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL reset_tx0 got=%h exp=00", r); end
      bus_read(16'd19, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL reset_rx1 got=%h exp=00", r); end
      bus_read(16'h0040, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL unmapped got=%h exp=00", r); end
      bus_write(16'd0, 8'h00);
      bus_read(16'h1000, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL out_of_range got=%h exp=00", r); end
   endtask

   task automatic test_basic_frame();
      logic [7:0]  r;
      logic [31:0] s;
      bus_write(16'd16, 8'hA5);
      bus_write(16'd17, 8'h3C);
      bus_read(16'd17, r);
      total++; if (r !== 8'h3C) begin bad++; $display("FAIL tx1_readback got=%h exp=3c", r); end
      full_frame(32'h1234, 16, 4, s);
      total++; if (s[15:0] !== 16'hA53C) begin bad++; $display("FAIL sdo_stream got=%h exp=a53c", s[15:0]); end
      bus_read(16'd18, r);
      total++; if (r !== 8'h12) begin bad++; $display("FAIL basic_rx0 got=%h exp=12", r); end
      bus_read(16'd19, r);
      total++; if (r !== 8'h34) begin bad++; $display("FAIL basic_rx1 got=%h exp=34", r); end
      bus_read(16'd2, r);
      total++; if (r !== 8'd16) begin bad++; $display("FAIL basic_cnt_lo got=%h exp=10", r); end
      bus_read(16'd3, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL basic_cnt_hi got=%h exp=00", r); end
      bus_write(16'd18, 8'h77);
      bus_read(16'd18, r);
      total++; if (r !== 8'h12) begin bad++; $display("FAIL rx_write_ignored got=%h exp=12", r); end
   endtask

   task automatic test_status();
      logic [7:0] r;
      bus_read(16'd1, r);
      total++; if (r !== 8'h01) begin bad++; $display("FAIL status_done got=%h exp=01", r); end
      bus_write(16'd1, 8'h00);
      bus_read(16'd1, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL status_clear got=%h exp=00", r); end
   endtask

   task automatic test_overflow();
      logic [7:0]  r;
      logic [31:0] s;
      full_frame(32'hFFFFF, 20, 4, s);
      bus_read(16'd18, r);
      total++; if (r !== 8'hFF) begin bad++; $display("FAIL ovf_rx0 got=%h exp=ff", r); end
      bus_read(16'd19, r);
      total++; if (r !== 8'hFF) begin bad++; $display("FAIL ovf_rx1 got=%h exp=ff", r); end
      bus_read(16'd2, r);
      total++; if (r !== 8'h14) begin bad++; $display("FAIL ovf_cnt_lo got=%h exp=14", r); end
      bus_read(16'd3, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL ovf_cnt_hi got=%h exp=00", r); end
      bus_read(16'd1, r);
      total++; if (r !== 8'h05) begin bad++; $display("FAIL ovf_status got=%h exp=05", r); end
   endtask

   task automatic test_short_frame();
      logic [7:0]  r;
      logic [31:0] s;
      bus_write(16'd1, 8'h00);
      bus_write(16'd16, 8'h00);
      bus_write(16'd17, 8'h00);
      full_frame(32'h5A, 8, 4, s);
      bus_read(16'd18, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL short_rx0 got=%h exp=00", r); end
      bus_read(16'd19, r);
      total++; if (r !== 8'h5A) begin bad++; $display("FAIL short_rx1 got=%h exp=5a", r); end
      bus_read(16'd2, r);
      total++; if (r !== 8'h08) begin bad++; $display("FAIL short_cnt got=%h exp=08", r); end
      bus_read(16'd1, r);
      total++; if (r !== 8'h01) begin bad++; $display("FAIL short_status got=%h exp=01", r); end
   endtask

   task automatic test_collisions();
      logic [7:0]  r;
      logic [31:0] s;
      // status write lands on the same clock edge as the SLD copy
      bus_write(16'd1, 8'h00);
      sen_on();
      send_bits(32'h1111, 16, 4, s);
      sen_off();
      sld = 1'b1;
      repeat (2) @(negedge clk);
      add = BASE + 16'd1; din = 8'h00; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      sld = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(16'd1, r);
      total++; if (r !== 8'h01) begin bad++; $display("FAIL done_set_wins got=%h exp=01", r); end
      // RX read lands on the copy edge and must see the old image
      sen_on();
      send_bits(32'h2222, 16, 4, s);
      sen_off();
      sld = 1'b1;
      repeat (2) @(negedge clk);
      add = BASE + 16'd18; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      r = dout;
      total++; if (r !== 8'h11) begin bad++; $display("FAIL rx_read_race got=%h exp=11", r); end
      @(negedge clk);
      sld = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(16'd18, r);
      total++; if (r !== 8'h22) begin bad++; $display("FAIL rx_after_race got=%h exp=22", r); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0]  r;
      logic [31:0] s;
      bus_write(16'd1, 8'h00);
      sen_on();
      send_bits(32'h1F, 5, 4, s);
      bus_read(16'd1, r);
      total++; if (r !== 8'h02) begin bad++; $display("FAIL busy_mid_frame got=%h exp=02", r); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send_bits(32'h7FF, 11, 4, s);
      total++; if (sdo !== 1'b0) begin bad++; $display("FAIL rst_sdo got=%b exp=0", sdo); end
      bus_read(16'd1, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL rst_not_busy got=%h exp=00", r); end
      sen_off();
      sld_pulse();
      bus_read(16'd1, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL rst_no_done got=%h exp=00", r); end
      bus_read(16'd19, r);
      total++; if (r !== 8'h00) begin bad++; $display("FAIL rst_no_capture got=%h exp=00", r); end
      full_frame(32'hC3A5, 16, 4, s);
      total++; if (s[15:0] !== 16'h0000) begin bad++; $display("FAIL rst_next_sdo got=%h exp=0000", s[15:0]); end
      bus_read(16'd18, r);
      total++; if (r !== 8'hC3) begin bad++; $display("FAIL rst_next_rx0 got=%h exp=c3", r); end
      bus_read(16'd19, r);
      total++; if (r !== 8'hA5) begin bad++; $display("FAIL rst_next_rx1 got=%h exp=a5", r); end
   endtask

   task automatic test_fast_random();
      logic [7:0]  r0, r1;
      logic [31:0] s, data;
      int          n;
      for (int f = 0; f < 100; f++) begin
         data = $urandom;
         n    = 16 + int'($urandom_range(0, 4));
         full_frame(data, n, 2, s);
         bus_read(16'd18, r0);
         bus_read(16'd19, r1);
         total++;
         if ({r0, r1} !== data[15:0]) begin
            bad++;
            $display("FAIL fast_frame_%0d got=%h exp=%h", f, {r0, r1}, data[15:0]);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_frame();
      test_status();
      test_overflow();
      test_short_frame();
      test_collisions();
      test_reset_mid_frame();
      test_fast_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
